// File: rtl/i2c_master_write_burst.sv
// I2C write master: START, 7-bit address + W, 0..MAX_BYTES data bytes, STOP.
// Every acknowledge is checked and the first NACK aborts straight to STOP.
module i2c_master_write_burst #(
  parameter int unsigned CLK_DIV   = 128,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [6:0]             dev_addr,
  input  logic [CNT_W-1:0]       num_bytes,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  output logic                   i2c_sclk,
  inout  wire                    i2c_sdat,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_ok,
  output logic [CNT_W-1:0]       nack_idx
);

  localparam int unsigned QTR  = CLK_DIV / 4;
  localparam int unsigned PH_W = $clog2(CLK_DIV);

  // Last cycle of each quarter; an update on that edge lands on the boundary.
  localparam logic [PH_W-1:0] PH_END_Q0 = PH_W'(QTR - 1);
  localparam logic [PH_W-1:0] PH_END_Q1 = PH_W'(2 * QTR - 1);
  localparam logic [PH_W-1:0] PH_END_Q2 = PH_W'(3 * QTR - 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HIGH   = PH_W'(2 * QTR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_DATA,
    S_ACK,
    S_STOP
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   pending;
  logic                   accept;
  logic [PH_W-1:0]        phase;
  logic                   phase_end;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic [8*MAX_BYTES-1:0] payload;
  logic [CNT_W-1:0]       n_bytes;
  logic [CNT_W-1:0]       pos;
  logic                   nack_smp;
  logic                   sda_low;
  logic                   sda_low_nxt;

  assign phase_end = (phase == PH_LAST);
  // A request is latched on one edge and the bit clock starts on the next.
  assign accept    = (state == S_IDLE) && !pending && start;

  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      phase   <= '0;
      sda_low <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= accept;
      sda_low <= sda_low_nxt;
      phase   <= (state == S_IDLE || phase_end) ? '0 : phase + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pending) state_nxt = S_START;
      S_START: if (phase_end) state_nxt = S_ADDR;
      S_ADDR, S_DATA: if (phase_end && bit_cnt == 3'd7) state_nxt = S_ACK;
      S_ACK: begin
        if (phase_end) begin
          if (nack_smp || pos >= n_bytes) state_nxt = S_STOP;
          else                            state_nxt = S_DATA;
        end
      end
      S_STOP:  if (phase_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    i2c_sclk    = 1'b1;
    sda_low_nxt = sda_low;
    case (state)
      S_IDLE:  sda_low_nxt = 1'b0;
      S_START: if (phase == PH_END_Q1) sda_low_nxt = 1'b1;
      S_ADDR, S_DATA: begin
        i2c_sclk = (phase >= PH_HIGH);
        if (phase == PH_END_Q0) sda_low_nxt = ~shreg[7];
      end
      S_ACK: begin
        i2c_sclk = (phase >= PH_HIGH);
        if (phase == PH_END_Q0)   sda_low_nxt = 1'b0;
        if (state_nxt == S_STOP)  sda_low_nxt = 1'b1;
      end
      S_STOP: begin
        i2c_sclk = (phase >= PH_HIGH);
        if (phase == PH_END_Q2) sda_low_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      payload  <= '0;
      n_bytes  <= '0;
      pos      <= '0;
      nack_smp <= 1'b0;
      done     <= 1'b0;
      ack_ok   <= 1'b1;
      nack_idx <= '0;
    end else begin
      done <= (state == S_STOP) && phase_end;
      if (accept) begin
        shreg    <= {dev_addr, 1'b0};
        payload  <= tx_data;
        n_bytes  <= (num_bytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : num_bytes;
        pos      <= '0;
        bit_cnt  <= '0;
        nack_smp <= 1'b0;
        ack_ok   <= 1'b1;
        nack_idx <= '0;
      end
      case (state)
        S_ADDR, S_DATA: begin
          if (phase_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= {shreg[6:0], 1'b0};
          end
        end
        S_ACK: begin
          if (phase == PH_END_Q2) nack_smp <= i2c_sdat;
          if (phase_end) begin
            if (nack_smp) begin
              ack_ok   <= 1'b0;
              nack_idx <= pos;
            end else begin
              // Payload is consumed low byte first by shifting it down.
              pos     <= pos + 1'b1;
              shreg   <= payload[7:0];
              payload <= payload >> 8;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_write_burst.sv
// Randomised bench for i2c_master_write_burst: a bus monitor with a simple
// slave decodes SCL/SDA and each transfer is compared with a transaction model.
module tb_i2c_master_write_burst;

  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned MAXB    = 4;
  localparam int unsigned CNT_W   = $clog2(MAXB + 1);

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [6:0]        dev_addr;
  logic [CNT_W-1:0]  num_bytes;
  logic [8*MAXB-1:0] tx_data;
  logic              i2c_sclk;
  logic              busy;
  logic              done;
  logic              ack_ok;
  logic [CNT_W-1:0]  nack_idx;
  wire               sda_bus;

  logic slave_low;
  logic prev_scl, prev_sda, pend_bit, pend_valid;
  bit   bits_q[$];
  int   start_cnt, stop_cnt;
  int   nack_pos;
  int   checks, errors;

  assign sda_bus = slave_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_master_write_burst #(
    .CLK_DIV  (CLK_DIV),
    .MAX_BYTES(MAXB),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dev_addr (dev_addr),
    .num_bytes(num_bytes),
    .tx_data  (tx_data),
    .i2c_sclk (i2c_sclk),
    .i2c_sdat (sda_bus),
    .busy     (busy),
    .done     (done),
    .ack_ok   (ack_ok),
    .nack_idx (nack_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  // Bus monitor and slave; a bit is committed on the SCL fall after its rise.
  initial begin
    start_cnt = 0;
    stop_cnt  = 0;
    slave_low = 1'b0;
    prev_scl  = 1'b1;
    prev_sda  = 1'b1;
    pend_bit  = 1'b0;
    pend_valid = 1'b0;
  end

  always @(negedge clk) begin : monitor
    logic c, s;
    int   n;
    c = i2c_sclk;
    s = (sda_bus !== 1'b0);
    if (prev_scl && c && prev_sda && !s) begin
      start_cnt <= start_cnt + 1;
      bits_q.delete();
      pend_valid <= 1'b0;
      slave_low  <= 1'b0;
    end
    if (prev_scl && c && !prev_sda && s) begin
      stop_cnt   <= stop_cnt + 1;
      pend_valid <= 1'b0;
    end
    if (!prev_scl && c) begin
      pend_bit   <= s;
      pend_valid <= 1'b1;
    end
    if (prev_scl && !c) begin
      n = bits_q.size();
      if (pend_valid) begin
        bits_q.push_back(pend_bit);
        n = n + 1;
      end
      pend_valid <= 1'b0;
      if (n % 9 == 8) slave_low <= ((n - 8) / 9 != nack_pos);
      else            slave_low <= 1'b0;
    end
    prev_scl <= c;
    prev_sda <= s;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // np: frame that the slave NACKs (0 = address), -1 = slave ACKs everything.
  task automatic run_xfer(input logic [6:0] a, input int n, input logic [8*MAXB-1:0] d,
                          input int np, input bit mid_start, input bit hold);
    int         nc, frames, exp_cyc, cyc, st0, sp0;
    bit         exp_ok;
    logic [7:0] exp_b[$];
    logic [7:0] got;

    nc = (n > int'(MAXB)) ? int'(MAXB) : n;
    exp_b.push_back({a, 1'b0});
    for (int k = 0; k < nc; k++) exp_b.push_back(d[8*k +: 8]);
    exp_ok  = !(np >= 0 && np <= nc);
    frames  = exp_ok ? nc + 1 : np + 1;
    exp_cyc = int'(CLK_DIV) * (2 + 9 * frames);

    nack_pos  = np;
    st0       = start_cnt;
    sp0       = stop_cnt;
    dev_addr  = a;
    num_bytes = CNT_W'(n);
    tx_data   = d;
    start     = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    dev_addr = 7'($urandom);
    tx_data  = $urandom;
    check("busy_after_accept", int'(busy), 0);
    @(negedge clk);
    check("busy_rise", int'(busy), 1);

    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mid_start && cyc == 40) begin
        start     = 1'b1;
        num_bytes = CNT_W'($urandom);
        dev_addr  = 7'($urandom);
      end
      if (mid_start && cyc == 42) start = hold;
    end while (!done && cyc < 4000);

    check("done_cycle", cyc, exp_cyc);
    check("busy_at_done", int'(busy), 0);
    check("ack_ok", int'(ack_ok), int'(exp_ok));
    check("nack_idx", int'(nack_idx), exp_ok ? 0 : np);
    check("start_conds", start_cnt - st0, 1);
    check("stop_conds", stop_cnt - sp0, 1);
    check("bit_count", bits_q.size(), 9 * frames);
    if (bits_q.size() >= 9 * frames) begin
      for (int f = 0; f < frames; f++) begin
        got = '0;
        for (int i = 0; i < 8; i++) got = {got[6:0], bits_q[9*f + i]};
        check($sformatf("byte%0d", f), int'(got), int'(exp_b[f]));
        check($sformatf("ackbit%0d", f), int'(bits_q[9*f + 8]), int'(f == np));
      end
    end

    @(negedge clk);
    check("done_width", int'(done), 0);
    check("scl_idle", int'(i2c_sclk), 1);
    check("sda_idle", int'(sda_bus !== 1'b0), 1);
    if (hold) begin
      check("restart_latch", int'(busy), 0);
      @(negedge clk);
      check("restart_busy", int'(busy), 1);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 4000) begin
        @(negedge clk);
        cyc++;
      end
      check("restart_done", int'(done), 1);
      @(negedge clk);
    end
  endtask

  task automatic reset_mid;
    int cyc, seen;
    nack_pos  = -1;
    dev_addr  = 7'h5A;
    num_bytes = CNT_W'(2);
    tx_data   = $urandom;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!busy && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    repeat (100) @(negedge clk);
    check("busy_before_reset", int'(busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_scl", int'(i2c_sclk), 1);
    check("rst_sda", int'(sda_bus !== 1'b0), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ack_ok", int'(ack_ok), 1);
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("rst_no_done", seen, 0);
  endtask

  initial begin
    int n, np;
    checks    = 0;
    errors    = 0;
    nack_pos  = -1;
    reset_n   = 1'b0;
    start     = 1'b0;
    dev_addr  = '0;
    num_bytes = '0;
    tx_data   = '0;
    repeat (3) @(negedge clk);
    check("reset_scl", int'(i2c_sclk), 1);
    check("reset_sda", int'(sda_bus !== 1'b0), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ack_ok", int'(ack_ok), 1);
    check("reset_nack_idx", int'(nack_idx), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(7'h27, 1, 32'h0000_00A5, -1, 1'b0, 1'b0);
    run_xfer(7'($urandom), 4, 32'h4433_2211, -1, 1'b0, 1'b0);
    run_xfer(7'($urandom), 3, $urandom, 2, 1'b0, 1'b0);
    run_xfer(7'($urandom), 2, $urandom, 0, 1'b0, 1'b0);
    run_xfer(7'($urandom), 7, $urandom, -1, 1'b1, 1'b0);
    run_xfer(7'($urandom), 0, $urandom, -1, 1'b0, 1'b1);
    reset_mid();
    run_xfer(7'h3C, 2, 32'h0000_C35A, -1, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      n  = int'($urandom_range(0, 7));
      np = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 5));
      run_xfer(7'($urandom), n, $urandom, np, 1'(t % 3 == 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
